// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32I instruction encoder (inverse of the immediate
// generator). Scatters a signed immediate plus register/function fields into a
// 32-bit instruction word and tags it with an auto-incrementing address.
//
// Optional feature macro: IMM_RANGE_CHECK_EN
//   defined   -> out-of-range / misaligned immediates give NOP + out_err
//   undefined -> immediates are truncated; out_err only for illegal formats
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid / in_ready         input handshake
//   in_fmt                      0=I 1=S 2=B 3=U 4=J 5=R, 6/7 illegal
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm
//   out_valid / out_ready       output handshake
//   out_instr, out_addr         encoded word and its memory address
//   out_err                     word was replaced/flagged as erroneous
//   err_count                   saturating count of emitted error words
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [15:0] err_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
    localparam logic [2:0] FMT_R = 3'd5;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    // S1 state
    logic    s1_valid_q, s1_valid_d;
    fields_t s1_q, s1_d;

    // S2 state
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_err_q, out_err_d;
    logic [31:0] out_addr_q, out_addr_d;
    logic [15:0] err_count_q, err_count_d;

    logic        s2_load;
    logic        s1_load;
    logic        out_hs;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic        range_err;

    // Handshake / advance control
    always_comb begin
        s2_load  = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = !s1_valid_q || s2_load;
        s1_load  = in_valid && in_ready;
        out_hs   = out_valid_q && out_ready;
    end

    // Immediate scatter on the S1 contents
    always_comb begin
        enc_instr = NOP;
        enc_err   = 1'b0;
        range_err = 1'b0;
        case (s1_q.fmt)
            FMT_I: enc_instr = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
            FMT_S: enc_instr = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                                s1_q.imm[4:0], s1_q.opcode};
            FMT_B: enc_instr = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                                s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
            FMT_U: enc_instr = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
            FMT_J: enc_instr = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12],
                                s1_q.rd, s1_q.opcode};
            FMT_R: enc_instr = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd,
                                s1_q.opcode};
            default: enc_err = 1'b1;  // illegal format: NOP + error in every build
        endcase

`ifdef IMM_RANGE_CHECK_EN
        case (s1_q.fmt)
            FMT_I, FMT_S:
                range_err = ($signed(s1_q.imm) < -32'sd2048) || ($signed(s1_q.imm) > 32'sd2047);
            FMT_B:
                range_err = ($signed(s1_q.imm) < -32'sd4096) || ($signed(s1_q.imm) > 32'sd4094)
                            || s1_q.imm[0];
            FMT_J:
                range_err = ($signed(s1_q.imm) < -32'sd1048576)
                            || ($signed(s1_q.imm) > 32'sd1048574) || s1_q.imm[0];
            FMT_U:
                range_err = (s1_q.imm[11:0] != 12'd0);
            default:
                range_err = 1'b0;
        endcase
        if (range_err) begin
            enc_instr = NOP;
            enc_err   = 1'b1;
        end
`endif
    end

    // Next-state for both stages
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        out_addr_d  = out_addr_q;
        err_count_d = err_count_q;

        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_d = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                     funct3: in_funct3, funct7: in_funct7, imm: in_imm};
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_instr;
            out_err_d   = enc_err;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Address tracks the word currently presented; wraps naturally at 2^32.
        if (out_hs) begin
            out_addr_d = out_addr_q + 32'd4;
            if (out_err_q && (err_count_q != 16'hFFFF))
                err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_err_q   <= 1'b0;
            out_addr_q  <= BASE_ADDR;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
            out_addr_q  <= out_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign out_addr  = out_addr_q;
    assign err_count = err_count_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RV32I instruction encoder: it is the inverse of the core's immediate generator. It accepts a format class, opcode, register/function fields and a 32-bit signed immediate, then scatters the immediate into the correct instruction bit positions. It emits a packed 32-bit instruction word tagged with an auto-incrementing instruction-memory address. It sits between the test/boot loader and the instruction memory write port.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: address tagged on the first instruction after reset.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: input fields valid.
- `in_ready`, out, 1: encoder can accept this cycle.
- `in_fmt`, in, 3: 0=I, 1=S, 2=B, 3=U, 4=J, 5=R, 6/7 illegal.
- `in_opcode`, in, 7: placed verbatim in bits [6:0].
- `in_rd`, `in_rs1`, `in_rs2`, in, 5 each: register fields.
- `in_funct3`, in, 3; `in_funct7`, in, 7: function fields.
- `in_imm`, in, 32: signed byte-offset/value immediate.
- `out_valid`, out, 1: output word valid.
- `out_ready`, in, 1: consumer accepts.
- `out_instr`, out, 32: encoded instruction.
- `out_addr`, out, 32: memory address for `out_instr`.
- `out_err`, out, 1: immediate out of range, misaligned, or format illegal.
- `err_count`, out, 16: saturating count of emitted words with `out_err`=1.

## Operation
- Two stages. S1 registers the accepted fields. S2 registers the encoded word, error flag and address.
- Transfer occurs on `valid && ready` at each end.
- Packing by format:
  - I: imm[11:0]→[31:20], rs1, funct3, rd.
  - S: imm[11:5]→[31:25], rs2, rs1, funct3, imm[4:0]→[11:7].
  - B: imm[12]→31, imm[10:5]→[30:25], rs2, rs1, funct3, imm[4:1]→[11:8], imm[11]→7.
  - U: imm[31:12]→[31:12], rd.
  - J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12], rd.
  - R: funct7, rs2, rs1, funct3, rd; `in_imm` ignored.
- Unused fields for a format are not encoded; bits come only from the listed sources.
- Illegal format (6/7): `out_instr`=32'h0000_0013 (NOP) and `out_err`=1, regardless of configuration.
- `out_addr` register starts at BASE_ADDR and advances by 4 on each output handshake. It wraps modulo 2^32 (32'hFFFF_FFFC → 0).
- `err_count` increments on an output handshake with `out_err`=1 and saturates at 16'hFFFF.

## Timing
- Reset values:
  - `out_valid`=0, `in_ready`=1.
  - `out_instr`=0, `out_err`=0.
  - `out_addr`=BASE_ADDR, `err_count`=0.
  - S1 valid=0.
- Latency: a word accepted in cycle N appears with `out_valid`=1 in cycle N+2 when no back-pressure.
- Throughput: 1 word/cycle with `out_ready` held high.
- S2 loads from S1 when S2 is empty or handshaking this cycle.
- S1 loads when S1 is empty or advancing.
- `in_ready` = !S1_valid || S1_advance.
- Back-pressure: up to 2 words are held; `in_ready` deasserts with both stages full and `out_ready`=0. Held outputs stay stable while `out_valid && !out_ready`.
- Reset mid-operation drops in-flight words and does not count them. The address restarts at BASE_ADDR.
- Simultaneous accept and emit in the same cycle is legal and loses nothing.

## Configuration
- `IMM_RANGE_CHECK_EN` defined, errors are flagged and the word is replaced by NOP (32'h0000_0013) under these conditions:
  - I/S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094] or imm[0]≠0.
  - J: imm outside [-2^20, 2^20-2] or imm[0]≠0.
  - U: imm[11:0]≠0.
- Not defined: out-of-range immediates are silently truncated to the encoded bits. `out_err` is 1 only for illegal formats.

## Test plan
- addi x1,x0,5 (fmt 0, opcode 0x13, rd 1, imm 5) → `out_instr`=0x00500093, `out_addr`=BASE_ADDR, 2 cycles after accept.
- sw x2,8(x1) (fmt 1, opcode 0x23, funct3 2, rs1 1, rs2 2, imm 8) → 0x0020A423. beq x0,x0,-4 (fmt 2, opcode 0x63, imm -4) → 0xFE000EE3.
- jal x1,2048 (fmt 4, opcode 0x6F, rd 1, imm 0x800) → 0x001000EF. Back-to-back with the previous words → addresses BASE, +4, +8, +12 consecutively.
- With `IMM_RANGE_CHECK_EN`: fmt 0 imm 2048 → 0x00000013, `out_err`=1, `err_count`=1. B imm 3 → `err_count`=2. Without the macro: fmt 0 imm 2048 → 0x80000093-style truncation, `out_err`=0.
- `out_ready`=0 for 4 cycles while 3 words are offered → `in_ready` low after 2 accepts. On release, words exit in order with no loss or duplication.
- `rst` asserted with 2 words in flight → next cycle `out_valid`=0, `out_addr`=BASE_ADDR, `err_count`=0. BASE_ADDR=0xFFFFFFFC with 2 words → addresses 0xFFFFFFFC then 0x00000000.
